stp_frame_buffer: RTL
=====================

Name: stp_frame_buffer

Overview:
Serial-to-parallel frame assembler sitting directly upstream of the PtS wrapper's parallel load port. It collects a stream of 16-bit samples into complete 32-point frames and presents each frame as 32 parallel words. The output words map one-to-one onto the PtS wrapper's in1..in32 inputs. It is double-buffered (ping-pong), so input streaming continues while one finished frame waits for the downstream load.

Parameters:
DATA_W, 16, sample width in bits
N_POINTS, 32, samples per frame; must be a power of 2 and at least 2
BIT_REVERSE, 0, 1 = store sample k at word bitrev(k) over log2(N_POINTS) bits (FFT input ordering); 0 = natural order

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data/in_sof valid this cycle
in_data  in  DATA_W  serial sample
in_sof  in  1  marks the first sample of a frame; qualified by in_valid
in_ready  out  1  block can accept a sample this cycle
out_valid  out  1  a complete frame is presented on out_data
out_ready  in  1  downstream takes the frame (drives the PtS load_strobe)
out_data  out  N_POINTS*DATA_W  word k occupies bits [DATA_W*k +: DATA_W]; word 0 feeds in1
resync  out  1  one-cycle pulse: a partial frame was discarded because of in_sof

Behaviour:
- Storage: two banks, each N_POINTS x DATA_W. Per-bank registers: wr_sel, rd_sel, full[1:0], plus write pointer ptr of width log2(N_POINTS).
- Accept condition: in_valid & in_ready. in_ready = !rst & !full[wr_sel].
- Write address: ptr, or bitrev(ptr) when BIT_REVERSE=1.
- On an accepted sample with in_sof=1:
  - Sample is written at logical index 0 and ptr <= 1.
  - If ptr != 0 beforehand, the partial frame is dropped and resync pulses high the next cycle.
  - in_sof with ptr == 0 is a normal first sample; no resync.
- On an accepted sample with in_sof=0: write at ptr, then ptr <= ptr+1.
  - Sampling is free-running; in_sof is never required.
- Frame complete (sample accepted at logical index N_POINTS-1):
  - full[wr_sel] <= 1, wr_sel toggles, ptr <= 0.
  - A sample with in_sof=1 at index N_POINTS-1 follows the sof rule instead (restart at index 0).
- Output side: out_valid = full[rd_sel]; out_data = bank[rd_sel].
  - out_data is held stable while out_valid & !out_ready.
  - On out_valid & out_ready: full[rd_sel] <= 0, rd_sel toggles.
- Latency: last sample accepted in cycle t -> out_valid high in cycle t+1, provided the read bank was empty.
- Simultaneous events:
  - Frame completion and an output handshake in the same cycle act on different banks; both take effect.
  - The next frame is presented at t+1 with no bubble.
- Backpressure: after two frames are held, in_ready stays low until an output handshake occurs. in_ready rises the cycle after that handshake.
  - Samples presented while in_ready=0 are ignored and never dropped silently.
- Throughput: one sample per clock sustained while out_ready keeps up. A frame may be taken every N_POINTS cycles.
- Reset, applied at any time including mid-frame:
  - Values: ptr=0, wr_sel=rd_sel=0, full=00, out_valid=0, resync=0, in_ready=0 during rst and 1 on the first cycle after.
  - Partial and held frames are discarded.
  - Bank contents are not reset; out_data is don't-care while out_valid=0.

Test Plan:
1. Natural order: BIT_REVERSE=0, out_ready=1, stream 0x0000..0x001F back-to-back -> out_valid high exactly 1 cycle after sample 0x1F; word k = k; out_valid high 1 cycle.
2. Backpressure: out_ready=0, stream 64 samples (0x00..0x3F) at in_valid=1 -> in_ready falls after the 64th accept while frame 1 (words 0x00..0x1F) holds stable. Then pulse out_ready for 1 cycle -> next cycle frame 2 (0x20..0x3F) presented and in_ready=1.
3. Resync: send 10 samples, then in_sof=1 with 0xA000 followed by 31 samples 0xA001..0xA01F -> resync pulses 1 cycle. Output frame word0=0xA000, word31=0xA01F; the first 10 samples never appear.
4. Bit reverse: BIT_REVERSE=1, sample k = k -> word1=0x0010, word2=0x0008, word31=0x001F, word0=0x0000.
5. Reset mid-operation: one frame held plus 20 samples of the next, then assert rst for 2 cycles -> out_valid=0 and in_ready=0 during rst. After rst, 32 fresh samples give out_valid after exactly 32 accepts.
6. Simultaneous: with a held frame presented, assert out_ready in the same cycle as the last sample of the next frame -> old frame released, new frame valid the next cycle, in_ready never drops.

Source files
------------

// File: rtl/stp_frame_buffer.sv
// stp_frame_buffer: ping-pong serial-to-parallel frame assembler feeding the PtS parallel load port
module stp_frame_buffer #(
    parameter int DATA_W      = 16,
    parameter int N_POINTS    = 32,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_sof,
    output logic                         in_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_POINTS*DATA_W-1:0]   out_data,
    output logic                         resync
);
    localparam int AW = $clog2(N_POINTS);

    logic [DATA_W-1:0] bank [2][N_POINTS];
    logic [AW-1:0]     ptr;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     waddr;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        full;
    logic              acc;
    logic              take;
    logic              last;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
        return r;
    endfunction

    // handshake qualifiers and write address; a start-of-frame always lands at index 0
    always_comb begin
        in_ready  = !rst && !full[wr_sel];
        out_valid = full[rd_sel];
        acc       = in_valid && in_ready;
        take      = out_valid && out_ready;
        last      = acc && !in_sof && ptr == AW'(N_POINTS - 1);
        idx       = in_sof ? '0 : ptr;
        waddr     = BIT_REVERSE ? bitrev(idx) : idx;
    end

    // control: a bank can only be filled while empty and drained while full, so the two never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= 2'b00;
            resync <= 1'b0;
        end else begin
            resync <= acc && in_sof && ptr != '0;
            if (acc) ptr <= in_sof ? AW'(1) : ptr + AW'(1);
            if (last) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= !wr_sel;
            end
            if (take) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= !rd_sel;
            end
        end
    end

    // sample storage; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (acc) bank[wr_sel][waddr] <= in_data;
    end

    for (genvar k = 0; k < N_POINTS; k++) begin : g_out
        assign out_data[DATA_W*k +: DATA_W] = bank[rd_sel][k];
    end
endmodule
